// File: rtl/ram_ctrl.sv
// Single-port RAM initiator: fill bursts on a request channel, read bursts on a response channel.
// Optional post-fill read-back verification with sticky err, enabled by defining RAM_CTRL_VERIFY_EN.
module ram_ctrl #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [N-1:0] req_adr,
    input  logic [N-1:0] req_len,
    input  logic [M-1:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [M-1:0] rsp_data,
    output logic         rsp_last,
    output logic         busy,
    output logic         mem_we,
    output logic [N-1:0] mem_adr,
    output logic [M-1:0] mem_din,
    input  logic [M-1:0] mem_dout,
    output logic         err
);

`ifdef RAM_CTRL_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD, RSP, VFY} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, RD, RSP} state_t;
`endif

    state_t         state_reg, state_next;
    logic [N-1:0]   cur_adr_reg, cur_adr_next;
    logic [N-1:0]   cnt_reg, cnt_next;
    logic [N-1:0]   len_reg, len_next;
    logic [M-1:0]   data_reg, data_next;
    logic [M-1:0]   rsp_data_reg, rsp_data_next;
    logic           rsp_valid_reg, rsp_valid_next;
    logic           rsp_last_reg, rsp_last_next;
`ifdef RAM_CTRL_VERIFY_EN
    logic [N-1:0]   start_adr_reg, start_adr_next;
    logic           err_reg, err_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cur_adr_reg   <= '0;
            cnt_reg       <= '0;
            len_reg       <= '0;
            data_reg      <= '0;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
            start_adr_reg <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cur_adr_reg   <= cur_adr_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            data_reg      <= data_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_last_reg  <= rsp_last_next;
`ifdef RAM_CTRL_VERIFY_EN
            start_adr_reg <= start_adr_next;
            err_reg       <= err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_adr_next   = cur_adr_reg;
        cnt_next       = cnt_reg;
        len_next       = len_reg;
        data_next      = data_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_last_next  = rsp_last_reg;
`ifdef RAM_CTRL_VERIFY_EN
        start_adr_next = start_adr_reg;
        err_next       = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cur_adr_next = req_adr;
                    len_next     = req_len;
                    data_next    = req_data;
                    cnt_next     = '0;
`ifdef RAM_CTRL_VERIFY_EN
                    start_adr_next = req_adr;
`endif
                    state_next   = req_write ? WR : RD;
                end
            end
            WR: begin
                if (cnt_reg == len_reg) begin
`ifdef RAM_CTRL_VERIFY_EN
                    // Rewind to the burst start so the read-back walks the same addresses.
                    cur_adr_next = start_adr_reg;
                    cnt_next     = '0;
                    state_next   = VFY;
`else
                    state_next   = IDLE;
`endif
                end else begin
                    cur_adr_next = cur_adr_reg + 1'b1;
                    cnt_next     = cnt_reg + 1'b1;
                end
            end
            RD: begin
                rsp_data_next  = mem_dout;
                rsp_valid_next = 1'b1;
                rsp_last_next  = (cnt_reg == len_reg);
                state_next     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (rsp_last_reg) begin
                        state_next = IDLE;
                    end else begin
                        cur_adr_next = cur_adr_reg + 1'b1;
                        cnt_next     = cnt_reg + 1'b1;
                        state_next   = RD;
                    end
                end
            end
`ifdef RAM_CTRL_VERIFY_EN
            VFY: begin
                if (mem_dout != data_reg) err_next = 1'b1;
                if (cnt_reg == len_reg) begin
                    state_next = IDLE;
                end else begin
                    cur_adr_next = cur_adr_reg + 1'b1;
                    cnt_next     = cnt_reg + 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Decoded straight from state so the async reset drops mem_we at once.
    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign mem_we    = (state_reg == WR);
    assign mem_adr   = cur_adr_reg;
    assign mem_din   = data_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_last  = rsp_last_reg;
`ifdef RAM_CTRL_VERIFY_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: behavioural RAM, table vectors, corner sequences, random commands.
module tb_ram_ctrl;
    logic        clk, reset_n;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_adr, req_len;
    logic [15:0] req_data;
    logic        rsp_valid, rsp_ready, rsp_last, busy, mem_we, err;
    logic [15:0] rsp_data, mem_din, mem_dout;
    logic [3:0]  mem_adr;

    logic [15:0] ram [16];
    logic [15:0] model [16];
    logic        stuck;
    int          checks, errors;

    ram_ctrl #(.N(4), .M(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_adr(req_adr), .req_len(req_len), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy), .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
        .mem_dout(mem_dout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_adr] <= mem_din;
    assign mem_dout = ram[mem_adr] & (stuck ? 16'hFFFE : 16'hFFFF);

    typedef struct {
        bit          wr;
        logic [3:0]  adr;
        logic [3:0]  len;
        logic [15:0] data;
        int          exp_busy;
        logic [15:0] exp_first;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input bit wr, input logic [3:0] adr, input logic [3:0] len,
                            input logic [15:0] data);
        int w = 0;
        while (!req_ready && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_adr = adr; req_len = len; req_data = data;
        step();
        req_valid = 1'b0;
        req_adr = 4'($urandom); req_len = 4'($urandom); req_data = 16'($urandom);
    endtask

    task automatic do_write(input logic [3:0] adr, input logic [3:0] len,
                            input logic [15:0] data, output int bcyc);
        logic [3:0] a;
        bcyc = 0;
        send_req(1'b1, adr, len, data);
        for (int i = 0; i <= int'(len); i++) begin
            a = adr + 4'(i);
            chk("wr_we", 32'(mem_we), 32'd1);
            chk("wr_adr", 32'(mem_adr), 32'(a));
            chk("wr_din", 32'(mem_din), 32'(data));
            if (busy) bcyc++;
            model[a] = data;
            step();
        end
`ifdef RAM_CTRL_VERIFY_EN
        for (int i = 0; i <= int'(len); i++) begin
            a = adr + 4'(i);
            chk("vfy_we", 32'(mem_we), 32'd0);
            chk("vfy_adr", 32'(mem_adr), 32'(a));
            if (busy) bcyc++;
            step();
        end
`endif
        chk("wr_done_ready", 32'(req_ready), 32'd1);
        chk("wr_done_we", 32'(mem_we), 32'd0);
        $display("txn write adr=%0d len=%0d data=%h busy_cycles=%0d", adr, len, data, bcyc);
    endtask

    task automatic do_read(input logic [3:0] adr, input logic [3:0] len, input int stall,
                           output logic [15:0] first, output int bcyc);
        logic [3:0]  a;
        logic [15:0] exp;
        bcyc = 0;
        first = 16'h0;
        send_req(1'b0, adr, len, 16'h0);
        for (int i = 0; i <= int'(len); i++) begin
            a = adr + 4'(i);
            exp = model[a];
            chk("rd_adr", 32'(mem_adr), 32'(a));
            chk("rd_we", 32'(mem_we), 32'd0);
            chk("rd_busy", 32'(busy), 32'd1);
            if (busy) bcyc++;
            step();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_data", 32'(rsp_data), 32'(exp));
            chk("rsp_last", 32'(rsp_last), 32'(i == int'(len)));
            if (i == 0) first = rsp_data;
            for (int s = 0; s < stall; s++) begin
                if (busy) bcyc++;
                step();
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_data", 32'(rsp_data), 32'(exp));
                chk("stall_adr", 32'(mem_adr), 32'(a));
                chk("stall_last", 32'(rsp_last), 32'(i == int'(len)));
            end
            rsp_ready = 1'b1;
            if (busy) bcyc++;
            step();
            rsp_ready = 1'b0;
        end
        chk("rd_done_busy", 32'(busy), 32'd0);
        chk("rd_done_ready", 32'(req_ready), 32'd1);
        chk("rd_done_valid", 32'(rsp_valid), 32'd0);
        $display("txn read adr=%0d len=%0d stall=%0d first=%h busy_cycles=%0d",
                 adr, len, stall, first, bcyc);
    endtask

    initial begin
        int          bc, w, wr_mul, st;
        logic [3:0]  ra, rl;
        logic [15:0] first, rd;
        checks = 0; errors = 0; stuck = 1'b0;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_adr = '0; req_len = '0;
        req_data = '0; rsp_ready = 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
        wr_mul = 2;
`else
        wr_mul = 1;
`endif
        vecs[0] = '{1'b1, 4'd3,  4'd0,  16'hBEEF, 1*wr_mul, 16'h0};
        vecs[1] = '{1'b1, 4'd14, 4'd3,  16'h00A5, 4*wr_mul, 16'h0};
        vecs[2] = '{1'b0, 4'd14, 4'd3,  16'h0,    8,        16'h00A5};
        vecs[3] = '{1'b0, 4'd2,  4'd0,  16'h0,    2,        16'h5A5A};
        vecs[4] = '{1'b0, 4'd13, 4'd0,  16'h0,    2,        16'h5A5A};
        vecs[5] = '{1'b0, 4'd3,  4'd0,  16'h0,    2,        16'hBEEF};
        vecs[6] = '{1'b0, 4'd15, 4'd15, 16'h0,    32,       16'h00A5};

        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_adr", 32'(mem_adr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);

        // Known RAM contents for everything that follows.
        do_write(4'd0, 4'd15, 16'h5A5A, bc);
        chk("prefill_busy", 32'(bc), 32'(16 * wr_mul));

        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                do_write(vecs[k].adr, vecs[k].len, vecs[k].data, bc);
            end else begin
                do_read(vecs[k].adr, vecs[k].len, 0, first, bc);
                chk("vec_first", 32'(first), 32'(vecs[k].exp_first));
            end
            chk("vec_busy", 32'(bc), 32'(vecs[k].exp_busy));
        end

        // Backpressure: 5 stalled cycles on each of two beats.
        do_read(4'd14, 4'd1, 5, first, bc);
        chk("bp_busy", 32'(bc), 32'd14);

        // Final rsp_ready together with req_valid: the request waits for IDLE.
        send_req(1'b0, 4'd3, 4'd0, 16'h0);
        step();
        chk("simul_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_adr = 4'd7; req_len = 4'd0; req_data = 16'h7777;
        step();
        rsp_ready = 1'b0;
        chk("simul_idle_busy", 32'(busy), 32'd0);
        chk("simul_idle_we", 32'(mem_we), 32'd0);
        step();
        req_valid = 1'b0;
        chk("simul_accept_we", 32'(mem_we), 32'd1);
        chk("simul_accept_adr", 32'(mem_adr), 32'd7);
        model[7] = 16'h7777;
        w = 0;
        while (busy && w < 50) begin step(); w++; end
        chk("simul_done", 32'(busy), 32'd0);
        do_read(4'd6, 4'd2, 1, first, bc);

        // Randomized commands against the model.
        for (int n = 0; n < 40; n++) begin
            ra = 4'($urandom); rl = 4'($urandom_range(0, 15));
            st = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, rl, 16'($urandom), bc);
                chk("rand_wr_busy", 32'(bc), 32'((int'(rl) + 1) * wr_mul));
            end else begin
                do_read(ra, rl, st, first, bc);
                chk("rand_rd_busy", 32'(bc), 32'((int'(rl) + 1) * (2 + st)));
            end
        end
        chk("err_clean", 32'(err), 32'd0);

        // Reset in the middle of a whole-RAM fill, after 5 writes.
        do_write(4'd0, 4'd15, 16'hC3C3, bc);
        send_req(1'b1, 4'd0, 4'd15, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            model[i] = 16'h1234;
            step();
        end
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_we_drop", 32'(mem_we), 32'd0);
        chk("async_busy_drop", 32'(busy), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_adr", 32'(mem_adr), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd = ram[i];
            chk("ram_after_abort", 32'(rd), 32'(model[i]));
        end
        do_read(4'd3, 4'd4, 0, first, bc);

`ifdef RAM_CTRL_VERIFY_EN
        stuck = 1'b1;
        do_write(4'd8, 4'd1, 16'h0001, bc);
        chk("err_set", 32'(err), 32'd1);
        stuck = 1'b0;
        do_read(4'd8, 4'd1, 0, first, bc);
        chk("err_sticky", 32'(err), 32'd1);
`else
        stuck = 1'b1;
        do_write(4'd8, 4'd1, 16'h0001, bc);
        stuck = 1'b0;
        chk("err_tied_low", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=%0d required=finish", checks);
        $fatal(1, "timeout");
    end
endmodule
